// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display scanner: glyph table,
// segment bit positions and legal parameter ranges.
package hex_display_pkg;

  localparam int unsigned NUM_DIGITS_MIN = 1;
  localparam int unsigned NUM_DIGITS_MAX = 8;
  localparam int unsigned SCAN_DIV_MIN   = 2;
  localparam int unsigned BLINK_DIV_MIN  = 1;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned GLYPH_N  = 16;

  localparam int unsigned SEG_TOP = 0;
  localparam int unsigned SEG_UR  = 1;
  localparam int unsigned SEG_LR  = 2;
  localparam int unsigned SEG_BOT = 3;
  localparam int unsigned SEG_LL  = 4;
  localparam int unsigned SEG_UL  = 5;
  localparam int unsigned SEG_MID = 6;

  localparam logic [SEG_W-1:0] M_T  = SEG_W'(1) << SEG_TOP;
  localparam logic [SEG_W-1:0] M_UR = SEG_W'(1) << SEG_UR;
  localparam logic [SEG_W-1:0] M_LR = SEG_W'(1) << SEG_LR;
  localparam logic [SEG_W-1:0] M_B  = SEG_W'(1) << SEG_BOT;
  localparam logic [SEG_W-1:0] M_LL = SEG_W'(1) << SEG_LL;
  localparam logic [SEG_W-1:0] M_UL = SEG_W'(1) << SEG_UL;
  localparam logic [SEG_W-1:0] M_M  = SEG_W'(1) << SEG_MID;

  // Active-high glyphs for 0..F, built from named segments.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [GLYPH_N] = '{
    M_T | M_UR | M_LR | M_B | M_LL | M_UL,          // 0
    M_UR | M_LR,                                    // 1
    M_T | M_UR | M_B | M_LL | M_M,                  // 2
    M_T | M_UR | M_LR | M_B | M_M,                  // 3
    M_UR | M_LR | M_UL | M_M,                       // 4
    M_T | M_LR | M_B | M_UL | M_M,                  // 5
    M_T | M_LR | M_B | M_LL | M_UL | M_M,           // 6
    M_T | M_UR | M_LR,                              // 7
    M_T | M_UR | M_LR | M_B | M_LL | M_UL | M_M,    // 8
    M_T | M_UR | M_LR | M_B | M_UL | M_M,           // 9
    M_T | M_UR | M_LR | M_LL | M_UL | M_M,          // A
    M_LR | M_B | M_LL | M_UL | M_M,                 // b
    M_T | M_B | M_LL | M_UL,                        // C
    M_UR | M_LR | M_B | M_LL | M_M,                 // d
    M_T | M_B | M_LL | M_UL | M_M,                  // E
    M_T | M_LL | M_UL | M_M                         // F
  };

endpackage

// File: rtl/seg_glyph_lut.sv
// Nibble to active-high seven-segment glyph; polarity is handled by the caller.
module seg_glyph_lut
  import hex_display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [SEG_W-1:0]    glyph_c
);

  always_comb begin
    glyph_c = GLYPH_TABLE[nibble_i];
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver with frame-synchronous loads,
// leading-zero suppression, per-digit blink and anti-ghost anode blanking.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_DIV  = 64,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_i,
  input  logic                           load_i,
  input  logic [NUM_DIGITS-1:0]          dp_i,
  input  logic [NUM_DIGITS-1:0]          blink_mask_i,
  input  logic                           lz_blank_i,
  input  logic                           enable_i,
  output logic [SEG_W-1:0]               seg_o,
  output logic                           dp_o,
  output logic [NUM_DIGITS-1:0]          an_o,
  output logic                           frame_o
);

  localparam int unsigned VAL_W  = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRM_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic                  POL     = (ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{POL}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

  if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX) begin : g_bad_num_digits
    $error("hex_display_scanner: NUM_DIGITS outside legal range");
  end
  if (SCAN_DIV < SCAN_DIV_MIN) begin : g_bad_scan_div
    $error("hex_display_scanner: SCAN_DIV below legal minimum");
  end
  if (BLINK_DIV < BLINK_DIV_MIN) begin : g_bad_blink_div
    $error("hex_display_scanner: BLINK_DIV below legal minimum");
  end

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [FRM_W-1:0]      frm_cnt_q, frm_cnt_d;
  logic                  blink_q, blink_d;
  logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  logic [VAL_W-1:0]      disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  slot_wrap_c;
  logic                  digit_last_c;
  logic                  frame_wrap_c;
  logic [NUM_DIGITS-1:0] sel_c;
  logic [NUM_DIGITS-1:0] lz_vec_c;
  logic [NIBBLE_W-1:0]   nibble_c;
  logic                  dp_sel_c;
  logic                  blank_c;
  logic [SEG_W-1:0]      glyph_c;
  logic [SEG_W-1:0]      seg_act_c;

  always_comb begin
    slot_wrap_c  = (slot_q == SLOT_W'(SCAN_DIV - 1));
    digit_last_c = (digit_q == DIG_W'(NUM_DIGITS - 1));
    frame_wrap_c = slot_wrap_c && digit_last_c;
  end

  // Scan timing: slot, digit index, blink phase.
  always_comb begin
    slot_d    = slot_wrap_c ? '0 : slot_q + SLOT_W'(1);
    digit_d   = digit_q;
    frm_cnt_d = frm_cnt_q;
    blink_d   = blink_q;
    if (slot_wrap_c) begin
      digit_d = digit_last_c ? '0 : digit_q + DIG_W'(1);
    end
    if (frame_wrap_c) begin
      if (frm_cnt_q == FRM_W'(BLINK_DIV - 1)) begin
        frm_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        frm_cnt_d = frm_cnt_q + FRM_W'(1);
      end
    end
    // Look one slot ahead so the registered pulse lands on the wrap cycle.
    frame_d = (slot_q == SLOT_W'(SCAN_DIV - 2)) && digit_last_c;
  end

  // Loads are held in a shadow and only reach the display at a frame boundary.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (load_i) begin
      shadow_val_d = value_i;
      shadow_dp_d  = dp_i;
    end
    if (frame_wrap_c) begin
      pending_d = 1'b0;
      if (load_i) begin
        disp_val_d = value_i;
        disp_dp_d  = dp_i;
      end else if (pending_q) begin
        disp_val_d = shadow_val_q;
        disp_dp_d  = shadow_dp_q;
      end
    end else if (load_i) begin
      pending_d = 1'b1;
    end
  end

  // Select the active digit and work out whether it is blanked.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    sel_c    = '0;
    lz_vec_c = '0;
    nibble_c = '0;
    dp_sel_c = 1'b0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run    = zero_run && (disp_val_q[k*NIBBLE_W +: NIBBLE_W] == '0);
      lz_vec_c[k] = lz_blank_i && zero_run && (k != 0);
      if (digit_q == DIG_W'(k)) begin
        sel_c[k] = 1'b1;
        nibble_c = disp_val_q[k*NIBBLE_W +: NIBBLE_W];
        dp_sel_c = disp_dp_q[k];
      end
    end
    blank_c = |(sel_c & (lz_vec_c | (blink_mask_i & {NUM_DIGITS{blink_q}})));
  end

  seg_glyph_lut u_lut (
    .nibble_i (nibble_c),
    .glyph_c  (glyph_c)
  );

  always_comb begin
    seg_act_c = blank_c ? '0 : glyph_c;
    seg_d     = seg_act_c ^ SEG_OFF;
    dp_d      = (dp_sel_c && !blank_c) ^ POL;
    an_d      = ((enable_i && (slot_q != '0)) ? sel_c : '0) ^ AN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      digit_q      <= '0;
      frm_cnt_q    <= '0;
      blink_q      <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= POL;
      an_q         <= AN_OFF;
      frame_q      <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      digit_q      <= digit_d;
      frm_cnt_q    <= frm_cnt_d;
      blink_q      <= blink_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: every cycle is compared against a reference
// model that derives scan position from the cycle count since reset.
module tb_hex_display_scanner;

  localparam int unsigned ND    = 4;
  localparam int unsigned SD    = 4;
  localparam int unsigned BD    = 2;
  localparam int unsigned FRAME = ND * SD;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_i;
  logic        load_i;
  logic [3:0]  dp_i;
  logic [3:0]  blink_mask_i;
  logic        lz_blank_i;
  logic        enable_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset release plus display/shadow contents.
  int          cyc;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dp, m_sdp;
  logic        m_pend;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD),
    .ACTIVE_LOW (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .value_i      (value_i),
    .load_i       (load_i),
    .dp_i         (dp_i),
    .blink_mask_i (blink_mask_i),
    .lz_blank_i   (lz_blank_i),
    .enable_i     (enable_i),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .frame_o      (frame_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    cyc      = 0;
    m_disp   = '0;
    m_shadow = '0;
    m_dp     = '0;
    m_sdp    = '0;
    m_pend   = 1'b0;
  endtask

  // One clock: predict outputs from the pre-edge state, advance the model, compare.
  task automatic tick();
    int         slot, dig, frm;
    logic       blank;
    logic [6:0] es;
    logic       ed;
    logic [3:0] ea;
    @(posedge clk);
    slot  = cyc % SD;
    dig   = (cyc / SD) % ND;
    frm   = cyc / FRAME;
    blank = (lz_blank_i && dig != 0 && (m_disp >> (4 * dig)) == 16'h0) ||
            (((frm / BD) % 2) == 1 && blink_mask_i[dig]);
    es    = blank ? 7'h00 : GLYPH[m_disp[4*dig +: 4]];
    ed    = !blank && m_dp[dig];
    ea    = (enable_i && slot != 0) ? 4'(1 << dig) : 4'h0;
    if (cyc % FRAME == FRAME - 1) begin
      if (load_i) begin
        m_disp = value_i;
        m_dp   = dp_i;
      end else if (m_pend) begin
        m_disp = m_shadow;
        m_dp   = m_sdp;
      end
      m_pend = 1'b0;
    end else if (load_i) begin
      m_shadow = value_i;
      m_sdp    = dp_i;
      m_pend   = 1'b1;
    end
    cyc++;
    #1;
    check("seg_o",   {25'b0, seg_o},   {25'b0, ~es});
    check("dp_o",    {31'b0, dp_o},    {31'b0, ~ed});
    check("an_o",    {28'b0, an_o},    {28'b0, ~ea});
    check("frame_o", {31'b0, frame_o}, {31'b0, (cyc % FRAME) == FRAME - 1});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model sits at the given position within the frame.
  task automatic run_to(input int phase);
    int guard;
    guard = 0;
    while ((cyc % FRAME) != phase && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    if ((cyc % FRAME) != phase) begin
      errors++;
      $error("FAIL run_to observed=%0d expected=%0d", cyc % FRAME, phase);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value_i = v;
    dp_i    = d;
    load_i  = 1'b1;
    tick();
    load_i  = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_seg",   {25'b0, seg_o},   32'h7F);
    check("rst_dp",    {31'b0, dp_o},    32'h1);
    check("rst_an",    {28'b0, an_o},    32'hF);
    check("rst_frame", {31'b0, frame_o}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_seg", {25'b0, seg_o}, 32'h7F);
    check("rst_hold_an",  {28'b0, an_o},  32'hF);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n        = 1'b0;
    value_i      = '0;
    load_i       = 1'b0;
    dp_i         = '0;
    blink_mask_i = '0;
    lz_blank_i   = 1'b0;
    enable_i     = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Idle scan of zeros with frame cadence.
    run(40);

    // Mid-frame load waits for the frame boundary.
    run_to(5);
    pulse_load(16'h12AF, 4'b0100);
    run(36);

    // Leading-zero suppression, including all-zero value keeping digit 0 and its dp.
    lz_blank_i = 1'b1;
    run_to(3);
    pulse_load(16'h0005, 4'b0010);
    run(40);
    pulse_load(16'h0000, 4'b0001);
    run(40);
    lz_blank_i = 1'b0;

    // Blink on digit 0 over several blink periods.
    blink_mask_i = 4'b0001;
    pulse_load(16'h1234, 4'b1111);
    run(160);
    blink_mask_i = 4'b0000;

    // Load coinciding with the frame wrap goes straight to the display.
    run_to(15);
    pulse_load(16'hABCD, 4'b1000);
    run(20);

    // Reset while a load is pending discards it.
    run_to(4);
    pulse_load(16'h5678, 4'b0110);
    run(3);
    do_reset();
    run(40);

    // Anodes off while disabled; counters keep running.
    pulse_load(16'h9E0C, 4'b0011);
    enable_i = 1'b0;
    run(32);
    enable_i = 1'b1;
    run(20);

    // Randomized traffic.
    for (int i = 0; i < 320; i++) begin
      value_i = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_i    = 4'($urandom);
      load_i  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) lz_blank_i = ~lz_blank_i;
      if ($urandom_range(0, 31) == 0) blink_mask_i = 4'($urandom);
      if ($urandom_range(0, 23) == 0) enable_i = ~enable_i;
      if (i == 160) begin
        load_i = 1'b0;
        do_reset();
      end
      tick();
    end
    load_i = 1'b0;
    run(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, digit count; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal values >= 2.
REQ-003 Parameter BLINK_DIV, default 64, frames per blink half-period; legal values >= 1.
REQ-004 Parameter ACTIVE_LOW, default 1; 1 = segments, dp and anodes driven active-low.
REQ-005 Port clk  input  1  single system clock, rising edge.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port value_i  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 is least significant.
REQ-008 Port load_i  input  1  one-cycle strobe that captures value_i and dp_i.
REQ-009 Port dp_i  input  NUM_DIGITS  per-digit decimal point, captured with value_i.
REQ-010 Port blink_mask_i  input  NUM_DIGITS  per-digit blink enable, used live.
REQ-011 Port lz_blank_i  input  1  leading-zero suppression enable, used live.
REQ-012 Port enable_i  input  1  0 = all anodes inactive.
REQ-013 Port seg_o  output  7  segments; bit0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle.
REQ-014 Port dp_o  output  1  decimal point of the active digit.
REQ-015 Port an_o  output  NUM_DIGITS  one-hot digit select.
REQ-016 Port frame_o  output  1  one-cycle pulse when the last digit slot ends.

Function
REQ-017 Slot counter counts 0..SCAN_DIV-1 and wraps; on wrap the digit index advances 0..NUM_DIGITS-1 and wraps to 0.
REQ-018 frame_o pulses in the cycle the slot counter wraps while the digit index is NUM_DIGITS-1.
REQ-019 load_i captures value_i/dp_i into a shadow register and sets a pending flag.
REQ-020 At frame wrap, shadow content is copied to the display register if pending, and pending clears.
REQ-021 If load_i coincides with frame wrap, value_i/dp_i go directly to the display register and pending clears.
REQ-022 Active-high glyphs (bit6..0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-023 If ACTIVE_LOW=1, seg_o, dp_o and an_o are inverted; a blank digit drives all segments inactive.
REQ-024 With lz_blank_i=1, a digit is blank when it and every higher digit are zero; digit 0 is never lz-blanked and its dp is still shown.
REQ-025 The blink phase toggles every BLINK_DIV frames; during phase 1, digits with blink_mask_i set are blank, including dp.
REQ-026 seg_o, dp_o and an_o are registered, reflecting the digit index with 1-cycle latency.
REQ-027 an_o is all-inactive during slot count 0 of every digit (anti-ghosting) and whenever enable_i=0.
REQ-028 Counters, blink phase and loads run regardless of enable_i.

Reset
REQ-029 rst_n low asynchronously clears slot counter, digit index, blink phase, frame counter, shadow, display register and pending flag.
REQ-030 During and after reset, seg_o, dp_o and an_o are at the inactive level (7'h7F, 1, all-ones for ACTIVE_LOW=1) and frame_o=0.
REQ-031 Reset mid-frame discards any pending load; the scan restarts at digit 0, slot 0.

Structure
REQ-032 Package hex_display_pkg holds the 16-entry glyph constant table, segment bit-index constants and the parameter legal-range limits.
REQ-033 One combinational sub-module seg_glyph_lut maps a 4-bit nibble to an active-high 7-bit glyph; polarity is applied in the parent.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2, ACTIVE_LOW=1)
REQ-034 Reset release, no load -> digits scan 0..3 every 16 cycles showing seg_o=7'h40 ("0"); frame_o every 16 cycles; an_o=4'hF in slot 0.
REQ-035 load_i with 16'h12AF mid-frame -> display unchanged until the next frame_o, then digit 3 seg_o=7'h79 ("1") and digit 0 seg_o=7'h0E ("F").
REQ-036 load_i with 16'h0005, lz_blank_i=1 -> digits 3..1 seg_o=7'h7F, digit 0 seg_o=7'h12; with 16'h0000, digit 0 still shows 7'h40.
REQ-037 blink_mask_i=4'b0001 -> digit 0 blank during frames 2-3, 6-7, ...; other digits steady.
REQ-038 load_i asserted in the frame-wrap cycle -> new value visible in the next frame; rst_n pulse while pending -> display returns to 0, the pending value is never shown.
REQ-039 enable_i=0 for 2 frames -> an_o=4'hF throughout; frame_o cadence unchanged.
